// File: rtl/rf_init_sequencer_if.sv
// Word channel between the init sequencer and the SPI shift stage.
// The master presents word_data/word_valid and the slave answers with word_ready.
`timescale 1ns/1ps
interface rf_init_sequencer_if #(
  parameter int WORD_W = 40
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/rf_init_sequencer.sv
// RF chip power-up sequencer: holds xreset_n low, waits for the chip to settle,
// then streams the ROM register-write table to the SPI stage one word at a time.
`timescale 1ns/1ps
module rf_init_sequencer #(
  parameter int                NUM_WRITES   = 16,
  parameter int                ADDR_W       = 4,
  parameter int                WORD_W       = 40,
  parameter int                RESET_CYCLES = 2000,
  parameter int                READY_WAIT   = 200,
  parameter logic [WORD_W-1:0] END_MARK     = {WORD_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  rf_init_sequencer_if.master spi,
  output logic              xreset_n,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (RESET_CYCLES > READY_WAIT) ? RESET_CYCLES : READY_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(READY_WAIT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_WRITES - 1);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    FETCH,
    LOAD,
    PRESENT,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [WORD_W-1:0] word_data_reg, word_data_next;
  logic              word_valid_reg, word_valid_next;
  logic              xreset_n_reg, xreset_n_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RST_HOLD;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      word_data_reg  <= '0;
      word_valid_reg <= 1'b0;
      xreset_n_reg   <= 1'b0;
      busy_reg       <= 1'b1;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      word_data_reg  <= word_data_next;
      word_valid_reg <= word_valid_next;
      xreset_n_reg   <= xreset_n_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    word_data_next  = word_data_reg;
    word_valid_next = word_valid_reg;
    xreset_n_next   = xreset_n_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;

    unique case (state_reg)
      RST_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next    = RST_WAIT;
          cnt_next      = '0;
          xreset_n_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      RST_WAIT: begin
        if (cnt_reg == WAIT_LAST) begin
          state_next = FETCH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // rom_addr already shows idx_reg; the ROM registers it on this edge.
      FETCH: state_next = LOAD;

      LOAD: begin
        if (rom_data == END_MARK) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          word_data_next  = rom_data;
          word_valid_next = 1'b1;
          state_next      = PRESENT;
        end
      end

      PRESENT: begin
        if (word_valid_reg && spi.word_ready) begin
          word_valid_next = 1'b0;
          // Last entry is found by comparison so the index never wraps.
          if (idx_reg == IDX_LAST) begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end

      DONE: begin
        word_valid_next = 1'b0;
        if (start) begin
          idx_next      = '0;
          cnt_next      = '0;
          done_next     = 1'b0;
          busy_next     = 1'b1;
          xreset_n_next = 1'b0;
          state_next    = RST_HOLD;
        end
      end

      default: state_next = RST_HOLD;
    endcase
  end

  assign rom_addr       = idx_reg;
  assign spi.word_data  = word_data_reg;
  assign spi.word_valid = word_valid_reg;
  assign xreset_n       = xreset_n_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;

endmodule

// File: tb/tb_rf_init_sequencer.sv
// Directed bench for rf_init_sequencer: three instances cover the 4-entry table,
// the 16-entry table (end mark, mid-run reset) and the single-entry table.
`timescale 1ns/1ps
module tb_rf_init_sequencer;
  localparam int                WORD_W   = 40;
  localparam logic [WORD_W-1:0] END_MARK = {WORD_W{1'b1}};
  localparam int                LIM      = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A: 4-entry table
  logic              rst_a = 1'b1, start_a = 1'b0, xrn_a, busy_a, done_a;
  logic [3:0]        addr_a;
  logic [WORD_W-1:0] rom_a [16];
  logic [WORD_W-1:0] rdata_a;
  rf_init_sequencer_if #(.WORD_W(WORD_W)) if_a ();
  always @(posedge clk) rdata_a <= rom_a[addr_a];
  rf_init_sequencer #(.NUM_WRITES(4), .ADDR_W(4)) u_a (
    .clk(clk), .reset(rst_a), .start(start_a), .rom_addr(addr_a), .rom_data(rdata_a),
    .spi(if_a), .xreset_n(xrn_a), .busy(busy_a), .done(done_a));

  // Instance B: 16-entry table
  logic              rst_b = 1'b1, start_b = 1'b0, xrn_b, busy_b, done_b;
  logic [3:0]        addr_b;
  logic [WORD_W-1:0] rom_b [16];
  logic [WORD_W-1:0] rdata_b;
  rf_init_sequencer_if #(.WORD_W(WORD_W)) if_b ();
  always @(posedge clk) rdata_b <= rom_b[addr_b];
  rf_init_sequencer #(.NUM_WRITES(16), .ADDR_W(4)) u_b (
    .clk(clk), .reset(rst_b), .start(start_b), .rom_addr(addr_b), .rom_data(rdata_b),
    .spi(if_b), .xreset_n(xrn_b), .busy(busy_b), .done(done_b));

  // Instance C: single-entry table
  logic              rst_c = 1'b1, start_c = 1'b0, xrn_c, busy_c, done_c;
  logic [0:0]        addr_c;
  logic [WORD_W-1:0] rom_c [2];
  logic [WORD_W-1:0] rdata_c;
  rf_init_sequencer_if #(.WORD_W(WORD_W)) if_c ();
  always @(posedge clk) rdata_c <= rom_c[addr_c];
  rf_init_sequencer #(.NUM_WRITES(1), .ADDR_W(1)) u_c (
    .clk(clk), .reset(rst_c), .start(start_c), .rom_addr(addr_c), .rom_data(rdata_c),
    .spi(if_c), .xreset_n(xrn_c), .busy(busy_c), .done(done_c));

  // Handshake monitors: one line per accepted word.
  logic [WORD_W-1:0] acc_a[$], acc_b[$], acc_c[$];
  int                cyc_a[$], cyc_b[$];
  int                addr3_hits_b = 0;

  always @(posedge clk) begin
    if (!rst_a && if_a.word_valid && if_a.word_ready) begin
      acc_a.push_back(if_a.word_data);
      cyc_a.push_back(cyc);
      $display("A word %0d accepted data=%h cycle=%0d", acc_a.size() - 1, if_a.word_data, cyc);
    end
    if (!rst_b && if_b.word_valid && if_b.word_ready) begin
      acc_b.push_back(if_b.word_data);
      cyc_b.push_back(cyc);
      $display("B word %0d accepted data=%h cycle=%0d", acc_b.size() - 1, if_b.word_data, cyc);
    end
    if (!rst_c && if_c.word_valid && if_c.word_ready) begin
      acc_c.push_back(if_c.word_data);
      $display("C word %0d accepted data=%h cycle=%0d", acc_c.size() - 1, if_c.word_data, cyc);
    end
    if (!rst_b && addr_b == 4'd3) addr3_hits_b <= addr3_hits_b + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n, base;
    logic stable;

    for (int i = 0; i < 16; i++) begin
      rom_a[i] = {8'hA0, 24'(i * 32'h010203), 8'(i)};
      rom_b[i] = {8'hB0, 24'(i * 32'h00F0F1), 8'(i)};
    end
    rom_b[2] = END_MARK;
    rom_c[0] = 40'h12_3456_789A;
    rom_c[1] = 40'hCC_CCCC_CCCC;
    if_a.word_ready = 1'b1;
    if_b.word_ready = 1'b1;
    if_c.word_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("a_rst_xreset_n", xrn_a, 0);
    chk("a_rst_word_valid", if_a.word_valid, 0);
    chk("a_rst_word_data", if_a.word_data, 0);
    chk("a_rst_rom_addr", addr_a, 0);
    chk("a_rst_busy", busy_a, 1);
    chk("a_rst_done", done_a, 0);

    // Power-up with ready tied high
    rst_a = 1'b0;
    n = 0; while (xrn_a !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("a_xreset_low_cycles", n, 2000);
    n = 0; while (if_a.word_valid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("a_first_valid_delay", n, 202);
    n = 0; while (done_a !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("a_done_seen", n < LIM, 1);
    chk("a_word_count", acc_a.size(), 4);
    for (int i = 0; i < acc_a.size() && i < 4; i++) chk("a_word_data", acc_a[i], rom_a[i]);
    for (int i = 1; i < cyc_a.size() && i < 4; i++) chk("a_word_spacing", cyc_a[i] - cyc_a[i-1], 3);
    if (cyc_a.size() == 4) chk("a_done_latency", cyc - cyc_a[3], 1);
    chk("a_busy_done", busy_a, 0);

    // Rerun from DONE with backpressure, random early ready, and a start while busy
    if_a.word_ready = 1'b0;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk("a_start_done_drop", done_a, 0);
    chk("a_start_xreset_n", xrn_a, 0);
    chk("a_start_busy", busy_a, 1);
    chk("a_start_rom_addr", addr_a, 0);
    n = 0; while (xrn_a !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("a_rerun_xreset_low_cycles", n, 2000);
    base = acc_a.size();
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (if_a.word_valid !== 1'b1 && n < LIM) begin
        if_a.word_ready = 1'($urandom_range(0, 1));
        @(negedge clk); n++;
      end
      if_a.word_ready = 1'b0;
      chk("a_bp_valid_wait", n < LIM, 1);
      stable = 1'b1;
      for (int j = 0; j < 50; j++) begin
        if (k == 0 && j == 25) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        stable &= (if_a.word_valid === 1'b1 && if_a.word_data === rom_a[k] && xrn_a === 1'b1 && busy_a === 1'b1);
      end
      chk("a_bp_hold_stable", stable, 1);
      if_a.word_ready = 1'b1; @(negedge clk); if_a.word_ready = 1'b0;
      chk("a_bp_accept_count", acc_a.size() - base, k + 1);
    end
    chk("a_bp_done", done_a, 1);
    for (int i = 0; i < 4 && base + i < acc_a.size(); i++) chk("a_bp_word_data", acc_a[base + i], rom_a[i]);

    // End mark at entry 2 of 16
    rst_b = 1'b0;
    n = 0; while (done_b !== 1'b1 && n < 3 * LIM) begin @(negedge clk); n++; end
    chk("b_end_done_seen", n < 3 * LIM, 1);
    chk("b_end_word_count", acc_b.size(), 2);
    for (int i = 0; i < acc_b.size() && i < 2; i++) chk("b_end_word_data", acc_b[i], rom_b[i]);
    chk("b_end_addr3_hits", addr3_hits_b, 0);
    if (cyc_b.size() == 2) chk("b_end_done_latency", cyc - cyc_b[1], 3);

    // Reset while presenting entry 5
    rom_b[2] = {8'hB0, 24'(2 * 32'h00F0F1), 8'd2};
    if_b.word_ready = 1'b0;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    base = acc_b.size();
    for (int k = 0; k < 5; k++) begin
      n = 0; while (if_b.word_valid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
      if_b.word_ready = 1'b1; @(negedge clk); if_b.word_ready = 1'b0;
    end
    n = 0; while (if_b.word_valid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("b_entry5_data", if_b.word_data, rom_b[5]);
    chk("b_pre_reset_count", acc_b.size() - base, 5);
    rst_b = 1'b1; @(negedge clk);
    chk("b_reset_word_valid", if_b.word_valid, 0);
    chk("b_reset_xreset_n", xrn_b, 0);
    chk("b_reset_rom_addr", addr_b, 0);
    rst_b = 1'b0;
    if_b.word_ready = 1'b1;
    n = 0; while (xrn_b !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("b_rerun_xreset_low_cycles", n, 2000);
    n = 0; while (if_b.word_valid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("b_rerun_first_valid_delay", n, 202);
    base = acc_b.size();
    n = 0; while (done_b !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("b_rerun_word_count", acc_b.size() - base, 16);
    for (int i = 0; i < 16 && base + i < acc_b.size(); i++) chk("b_rerun_word_data", acc_b[base + i], rom_b[i]);

    // Single-entry table; start coincides with the final handshake
    rst_c = 1'b0;
    n = 0; while (if_c.word_valid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    chk("c_first_valid_delay", n, 2202);
    start_c = 1'b1; @(negedge clk); start_c = 1'b0;
    chk("c_done_after_handshake", done_c, 1);
    chk("c_xreset_kept", xrn_c, 1);
    chk("c_valid_dropped", if_c.word_valid, 0);
    repeat (5) @(negedge clk);
    chk("c_done_held", done_c, 1);
    chk("c_busy_low", busy_c, 0);
    chk("c_word_count", acc_c.size(), 1);
    if (acc_c.size() > 0) chk("c_word_data", acc_c[0], rom_c[0]);
    start_c = 1'b1; @(negedge clk); start_c = 1'b0;
    chk("c_start_done_drop", done_c, 0);
    chk("c_start_xreset_n", xrn_c, 0);
    chk("c_start_busy", busy_c, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_init_sequencer.md
# rf_init_sequencer

Power-up and configuration sequencer for the RF chip. It drives the chip's active-low reset pin through the hold/settle sequence, then walks a table of 40-bit SPI register-write words held in an external synchronous ROM. It hands each word to the downstream SPI shift stage over a valid/ready handshake. It sits directly upstream of the SPI master and is the only source of words that stage transmits.

## Interface
Parameters:
- NUM_WRITES, default 16: number of table entries, from 1 to 2^ADDR_W.
- ADDR_W, default 4: ROM address width.
- WORD_W, default 40: SPI word width.
- RESET_CYCLES, default 2000: number of cycles xreset_n is held low.
- READY_WAIT, default 200: number of cycles after xreset_n rises before the first ROM fetch.
- END_MARK, default 40'hFF_FFFF_FFFF: table terminator word.

Ports:
- clk  in  1: system clock, single clock domain.
- reset  in  1: synchronous, active-high reset.
- start  in  1: single-cycle pulse that re-runs the full sequence. Honoured only when done=1.
- rom_addr  out  ADDR_W: ROM read address.
- rom_data  in  WORD_W: ROM read data, registered, 1-cycle latency.
- word_data  out  WORD_W: word presented to the SPI stage.
- word_valid  out  1: word_data is valid.
- word_ready  in  1: SPI stage accepts the word.
- xreset_n  out  1: RF chip reset, active low.
- busy  out  1: sequence in progress.
- done  out  1: table finished; stays high until start or reset.

## Operation
- State machine states: RST_HOLD, RST_WAIT, FETCH, LOAD, PRESENT, DONE.
- Reset values: state=RST_HOLD, xreset_n=0, word_valid=0, word_data=0, rom_addr=0, busy=1, done=0, cycle counter=0.
- The sequence starts automatically after reset is released. No start pulse is needed after reset.
- RST_HOLD: xreset_n=0. The counter counts to RESET_CYCLES-1, then the state moves to RST_WAIT and xreset_n is set to 1.
- RST_WAIT: counter is cleared on entry and counts to READY_WAIT-1, then the state moves to FETCH.
- FETCH: rom_addr=index. The state moves to LOAD on the next cycle.
- LOAD:
  - If rom_data==END_MARK, go to DONE. Nothing is presented for that entry.
  - Otherwise, register rom_data into word_data, set word_valid=1, and go to PRESENT.
- PRESENT: word_valid and word_data are held stable until the cycle in which word_valid && word_ready are both high. At that edge:
  - word_valid is set to 0.
  - If index==NUM_WRITES-1, go to DONE.
  - Otherwise, index is incremented and the state moves to FETCH.
- DONE: busy=0, done=1, word_valid=0, xreset_n stays 1.
  - On start=1: index=0, counter=0, done=0, busy=1, xreset_n=0, and the state moves to RST_HOLD. This is a full re-run including the chip reset.
- Counter width is $clog2(max(RESET_CYCLES,READY_WAIT)+1) bits. Index width is ADDR_W bits. Index never wraps: the end of the table is detected by comparison, not by overflow.
- start in any state other than DONE is ignored.
- word_ready while word_valid=0 is ignored. An early ready is not remembered.
- reset asserted mid-operation:
  - All registers return to their reset values on that edge.
  - A word that is being presented is dropped.
  - xreset_n goes low immediately, and the full sequence restarts.

## Timing
- Edge 0 is the first rising edge at which reset=0.
- xreset_n is 0 for edges 0 through RESET_CYCLES-1 and becomes 1 after edge RESET_CYCLES-1, giving exactly RESET_CYCLES cycles low.
- rom_addr is valid in FETCH on the cycle READY_WAIT cycles after xreset_n rises.
- word_valid rises 2 cycles after FETCH is entered (FETCH then LOAD).
- If a handshake occurs at edge N, word_valid is 0 for cycles N+1 and N+2 and high again after edge N+2. The per-word overhead is therefore 3 cycles plus the SPI stage's busy time.
- With word_ready held at 1, word k is accepted 3 cycles after word k-1.
- done rises on the edge after the final handshake, or on the edge after LOAD sees END_MARK.

## Test plan
- Power-up, 4-entry table, word_ready tied to 1:
  - xreset_n low for exactly 2000 cycles.
  - First word_valid rises 202 cycles after xreset_n rises.
  - Four words are accepted in ROM order, 3 cycles apart.
  - done=1 and busy=0 one cycle after the fourth handshake.
- Backpressure: hold word_ready=0 for 50 cycles, with random ready before valid.
  - word_data stays stable and word_valid stays high.
  - Each word is accepted exactly once.
  - No word is skipped or duplicated.
- END_MARK at entry 2 of 16: exactly 2 words are transferred, then done=1. ROM address 3 is never driven.
- Reset asserted while in PRESENT on entry 5:
  - The next cycle shows word_valid=0, xreset_n=0, rom_addr=0.
  - The sequence reruns from entry 0 after another 2000+200 cycles.
- start pulses:
  - start while busy has no effect.
  - start in DONE drops done and pulls xreset_n low for 2000 cycles, then replays the table identically.
- NUM_WRITES=1 and ADDR_W=1: a single word is transferred, then done. start and word_ready both high in the same cycle as DONE is entered are handled as specified (start honoured only from the DONE state).
